// File: rtl/fsub_share_ctrl.sv
// Round-robin front end that time-shares one combinational FP subtractor between two requesters.
// Holds the granted operands for FSUB_LAT cycles, then returns the sampled result over valid/ready.
module fsub_share_ctrl #(
    parameter int FSUB_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_op_a,
    input  logic [31:0]      req0_op_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_op_a,
    input  logic [31:0]      req1_op_b,
    output logic [31:0]      fsub_op_a,
    output logic [31:0]      fsub_op_b,
    input  logic [31:0]      fsub_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(FSUB_LAT);

    state_t           state_reg, state_next;
    logic [31:0]      op_a_reg, op_b_reg;
    logic [31:0]      rsp_data_reg;
    logic             rsp_id_reg;
    logic             prio_reg;
    logic [3:0]       wait_reg;
    logic [CNT_W-1:0] op_count_reg;

    logic             grant_valid;
    logic             grant_id;
    logic             accept;
    logic             rsp_fire;
    logic [31:0]      grant_op_a;
    logic [31:0]      grant_op_b;

    // On a tie the pointer decides; otherwise whoever is valid wins.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = (req0_valid & req1_valid) ? prio_reg : req1_valid;
        grant_op_a  = grant_id ? req1_op_a : req0_op_a;
        grant_op_b  = grant_id ? req1_op_b : req0_op_b;
    end

    assign accept     = (state_reg == IDLE) & grant_valid;
    assign rsp_fire   = (state_reg == RESP) & rsp_ready;
    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept & grant_id;

    assign fsub_op_a  = op_a_reg;
    assign fsub_op_b  = op_b_reg;
    assign rsp_valid  = (state_reg == RESP);
    assign rsp_data   = rsp_data_reg;
    assign rsp_id     = rsp_id_reg;
    assign busy       = (state_reg != IDLE);
    assign op_count   = op_count_reg;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    if (wait_reg == 4'd1) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            op_a_reg     <= 32'd0;
            op_b_reg     <= 32'd0;
            rsp_data_reg <= 32'd0;
            rsp_id_reg   <= 1'b0;
            prio_reg     <= 1'b0;
            wait_reg     <= 4'd0;
            op_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_a_reg   <= grant_op_a;
                op_b_reg   <= grant_op_b;
                rsp_id_reg <= grant_id;
                wait_reg   <= LAT_LOAD;
            end
            // The result is sampled on the last settle cycle, never earlier.
            if (state_reg == EXEC) begin
                wait_reg <= wait_reg - 4'd1;
                if (wait_reg == 4'd1) begin
                    rsp_data_reg <= fsub_res;
                end
            end
            if (rsp_fire) begin
                op_count_reg <= op_count_reg + CNT_W'(1);
                prio_reg     <= ~rsp_id_reg;
            end
        end
    end

endmodule

// File: tb/tb_fsub_share_ctrl.sv
// Bench for fsub_share_ctrl: two instances (FSUB_LAT=1/CNT_W=16 and FSUB_LAT=3/CNT_W=4)
// checked every cycle against a transaction-timing model, plus directed literal checks.
module tb_fsub_share_ctrl;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk;
    logic        rst_n;
    logic        req_valid [2][2];
    logic        req_ready [2][2];
    logic [31:0] req_a     [2][2];
    logic [31:0] req_b     [2][2];
    logic [31:0] fa        [2];
    logic [31:0] fb        [2];
    logic [31:0] fres      [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_id    [2];
    logic        busy      [2];
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    logic [31:0] dly1_reg, dly2_reg;

    int tests  = 0;
    int failed = 0;
    bit chk_en = 0;

    // Behavioural model state: whether an op is outstanding and how many cycles it has aged.
    bit          m_busy [2];
    int          m_el   [2];
    int          m_cnt  [2];
    bit          m_ptr  [2];
    bit          m_id   [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_b    [2];
    logic [31:0] m_res  [2];
    logic [31:0] m_data [2];

    fsub_share_ctrl #(.FSUB_LAT(LAT0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[0][0]), .req0_ready(req_ready[0][0]),
        .req0_op_a(req_a[0][0]), .req0_op_b(req_b[0][0]),
        .req1_valid(req_valid[0][1]), .req1_ready(req_ready[0][1]),
        .req1_op_a(req_a[0][1]), .req1_op_b(req_b[0][1]),
        .fsub_op_a(fa[0]), .fsub_op_b(fb[0]), .fsub_res(fres[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .rsp_id(rsp_id[0]),
        .busy(busy[0]), .op_count(cnt0)
    );

    fsub_share_ctrl #(.FSUB_LAT(LAT1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[1][0]), .req0_ready(req_ready[1][0]),
        .req0_op_a(req_a[1][0]), .req0_op_b(req_b[1][0]),
        .req1_valid(req_valid[1][1]), .req1_ready(req_ready[1][1]),
        .req1_op_a(req_a[1][1]), .req1_op_b(req_b[1][1]),
        .fsub_op_a(fa[1]), .fsub_op_b(fb[1]), .fsub_res(fres[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .rsp_id(rsp_id[1]),
        .busy(busy[1]), .op_count(cnt1)
    );

    // Stand-in subtractor: exact for the directed values, arbitrary but deterministic otherwise.
    function automatic logic [31:0] fsub_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        if (a == b) return 32'h00000000;
        return (a - b) ^ 32'h8000_0001;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    // Requester the model says must see ready this cycle, or -1.
    function automatic int exp_grant(input int d);
        if (m_busy[d]) return -1;
        if (req_valid[d][0] && req_valid[d][1]) return int'(m_ptr[d]);
        if (req_valid[d][0]) return 0;
        if (req_valid[d][1]) return 1;
        return -1;
    endfunction

    task automatic check(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL dut%0d %s: got %h expected %h at %0t", d, name, act, exp, $time);
        end
    endtask

    task automatic wait_rsp(input int d, input int budget);
        int n;
        n = 0;
        while (rsp_valid[d] !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        check(d, "rsp_valid_timeout", rsp_valid[d], 1);
    endtask

    task automatic wait_ready(input int d, input int r, input int budget);
        int n;
        n = 0;
        while (req_ready[d][r] !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        check(d, "ready_timeout", req_ready[d][r], 1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign fres[0] = fsub_model(fa[0], fb[0]);
    assign fres[1] = dly2_reg;

    // Slow datapath for the FSUB_LAT=3 instance: result lags the operands by two cycles.
    always_ff @(posedge clk) begin
        dly1_reg <= fsub_model(fa[1], fb[1]);
        dly2_reg <= dly1_reg;
    end

    // Reference model, advanced on each rising edge from the inputs held across it.
    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_busy[d] = 0; m_el[d] = 0; m_cnt[d] = 0; m_ptr[d] = 0; m_id[d] = 0;
                m_a[d] = '0; m_b[d] = '0; m_res[d] = '0; m_data[d] = '0;
            end else if (!m_busy[d]) begin
                if (exp_grant(d) >= 0) begin
                    m_id[d]   = (exp_grant(d) == 1);
                    m_a[d]    = req_a[d][int'(m_id[d])];
                    m_b[d]    = req_b[d][int'(m_id[d])];
                    m_res[d]  = fsub_model(m_a[d], m_b[d]);
                    m_el[d]   = 0;
                    m_busy[d] = 1;
                end
            end else if (m_el[d] >= lat_of(d)) begin
                if (rsp_ready[d]) begin
                    m_busy[d] = 0;
                    m_cnt[d]  = m_cnt[d] + 1;
                    m_ptr[d]  = !m_id[d];
                end
            end else begin
                m_el[d] = m_el[d] + 1;
                if (m_el[d] == lat_of(d)) m_data[d] = m_res[d];
            end
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check(d, "req0_ready", req_ready[d][0], exp_grant(d) == 0);
                check(d, "req1_ready", req_ready[d][1], exp_grant(d) == 1);
                check(d, "busy", busy[d], m_busy[d]);
                check(d, "rsp_valid", rsp_valid[d], m_busy[d] && (m_el[d] >= lat_of(d)));
                check(d, "rsp_data", rsp_data[d], m_data[d]);
                check(d, "rsp_id", rsp_id[d], m_id[d]);
                check(d, "fsub_op_a", fa[d], m_a[d]);
                check(d, "fsub_op_b", fb[d], m_b[d]);
                check(d, "op_count", (d == 0) ? {16'd0, cnt0} : {28'd0, cnt1},
                      32'(m_cnt[d] % ((d == 0) ? 65536 : 16)));
            end
        end
    end

    initial begin
        logic hs [2][2];
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rsp_ready[d] = 1'b0;
            for (int n = 0; n < 2; n++) begin
                req_valid[d][n] = 1'b0; req_a[d][n] = '0; req_b[d][n] = '0;
            end
        end
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check(0, "reset_busy", busy[0], 0);
        check(1, "reset_rsp_valid", rsp_valid[1], 0);
        check(1, "reset_op_count", {28'd0, cnt1}, 0);
        check(0, "reset_fsub_op_a", fa[0], 0);

        // Single op on the FSUB_LAT=1 instance.
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid[0][0] = 1'b1; req_a[0][0] = 32'h40400000; req_b[0][0] = 32'h3F800000;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check(0, "t1_ready", req_ready[0][0], 1);
        @(posedge clk); #1;
        req_valid[0][0] = 1'b0;
        @(negedge clk);
        check(0, "t1_exec_no_rsp", rsp_valid[0], 0);
        check(0, "t1_op_a", fa[0], 32'h40400000);
        @(posedge clk); #1;
        @(negedge clk);
        check(0, "t1_rsp_valid", rsp_valid[0], 1);
        check(0, "t1_rsp_data", rsp_data[0], 32'h40000000);
        check(0, "t1_rsp_id", rsp_id[0], 0);
        @(posedge clk); #1;
        @(negedge clk);
        check(0, "t1_op_count", {16'd0, cnt0}, 1);

        // Ties after reset alternate 0,1,0,1.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid[0][0] = 1'b1; req_a[0][0] = 32'h40A00000; req_b[0][0] = 32'h40A00000;
        req_valid[0][1] = 1'b1; req_a[0][1] = 32'h40400000; req_b[0][1] = 32'h3F800000;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            wait_rsp(0, 10);
            check(0, "t2_rr_id", rsp_id[0], k % 2);
            check(0, "t2_rr_data", rsp_data[0], (k % 2 == 1) ? 32'h40000000 : 32'h00000000);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid[0][0] = 1'b0; req_valid[0][1] = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // FSUB_LAT=3 latency with a lagging datapath, then response backpressure.
        req_valid[1][0] = 1'b1; req_a[1][0] = 32'h40400000; req_b[1][0] = 32'h3F800000;
        req_valid[1][1] = 1'b1; req_a[1][1] = 32'h00001234; req_b[1][1] = 32'h00005678;
        rsp_ready[1] = 1'b0;
        @(negedge clk);
        check(1, "t3_ready0", req_ready[1][0], 1);
        check(1, "t3_ready1", req_ready[1][1], 0);
        @(posedge clk); #1;
        req_valid[1][0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(1, "t3_latency", rsp_valid[1], i == 3);
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        check(1, "t3_rsp_data", rsp_data[1], 32'h40000000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check(1, "t3_hold_valid", rsp_valid[1], 1);
            check(1, "t3_hold_data", rsp_data[1], 32'h40000000);
            check(1, "t3_hold_id", rsp_id[1], 0);
            check(1, "t3_hold_op_a", fa[1], 32'h40400000);
            check(1, "t3_hold_op_b", fb[1], 32'h3F800000);
            check(1, "t3_blocked_ready1", req_ready[1][1], 0);
        end
        @(posedge clk); #1;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        check(1, "t3_ready1_still_low", req_ready[1][1], 0);
        @(posedge clk); #1;
        @(negedge clk);
        check(1, "t3_ready1_rises", req_ready[1][1], 1);
        @(posedge clk); #1;
        req_valid[1][1] = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Reset while the FSUB_LAT=3 instance is in EXEC.
        req_valid[1][0] = 1'b1; req_a[1][0] = 32'h3F800000; req_b[1][0] = 32'h40400000;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid[1][0] = 1'b0;
        @(negedge clk);
        check(1, "t4_busy_before", busy[1], 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check(1, "t4_busy", busy[1], 0);
        check(1, "t4_rsp_valid", rsp_valid[1], 0);
        check(1, "t4_op_count", {28'd0, cnt1}, 0);
        check(1, "t4_op_a", fa[1], 0);
        check(1, "t4_op_b", fb[1], 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check(1, "t4_no_stale_rsp", rsp_valid[1], 0);
        end
        @(posedge clk); #1;

        // op_count wrap on the CNT_W=4 instance.
        rsp_ready[1] = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            req_valid[1][1] = 1'b1; req_a[1][1] = $urandom; req_b[1][1] = $urandom;
            @(negedge clk);
            wait_ready(1, 1, 20);
            @(posedge clk); #1;
            req_valid[1][1] = 1'b0;
            @(negedge clk);
            wait_rsp(1, 20);
            @(posedge clk); #1;
            @(negedge clk);
            if (k >= 15) check(1, "t5_wrap", {28'd0, cnt1}, k % 16);
            @(posedge clk); #1;
        end

        // Randomized traffic with occasional aborted requests and resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                for (int n = 0; n < 2; n++)
                    hs[d][n] = req_valid[d][n] & req_ready[d][n];
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 249) != 0);
            for (int d = 0; d < 2; d++) begin
                rsp_ready[d] = ($urandom_range(0, 3) != 0);
                for (int n = 0; n < 2; n++) begin
                    if (!req_valid[d][n] || hs[d][n]) begin
                        req_valid[d][n] = ($urandom_range(0, 2) == 0);
                        req_a[d][n] = $urandom;
                        req_b[d][n] = ($urandom_range(0, 3) == 0) ? req_a[d][n] : $urandom;
                    end else if ($urandom_range(0, 39) == 0) begin
                        req_valid[d][n] = 1'b0;
                    end
                end
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rsp_ready[d] = 1'b1;
            req_valid[d][0] = 1'b0;
            req_valid[d][1] = 1'b0;
        end
        repeat (12) @(posedge clk);
        @(negedge clk);
        check(0, "drain_idle", busy[0], 0);
        check(1, "drain_idle", busy[1], 0);
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
